divf32_seq: RTL and testbench

//  Iterative IEEE-754 binary32 divider, result = a / b; companion to the combinational binary32 multiplier.

---
 rtl/divf32_if.sv | 15 +
 rtl/divf32_seq.sv | 167 ++++++++++++++++
 tb/tb_divf32_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/divf32_if.sv
// Handshake and operand/result bundle for the sequential binary32 divider.
// The master drives the request and operands; the slave returns status and result.
interface divf32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        dz;
  logic        invalid;

  modport master (output start, a, b, input busy, done, result, dz, invalid);
  modport slave  (input start, a, b, output busy, done, result, dz, invalid);
endinterface

// File: rtl/divf32_seq.sv
// Iterative binary32 divider: restoring radix-2 mantissa division, one quotient bit
// per clock, flush-to-zero for subnormals, round-to-nearest-even.
module divf32_seq (
  input  logic     clk,
  input  logic     rst,
  divf32_if.slave  bus
);
  localparam int QBITS = 26;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic [31:0]       r_a, r_b;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [24:0]       r_rem;
  logic [23:0]       r_mb;
  logic [25:0]       r_q;
  logic [4:0]        r_cnt;
  logic [22:0]       r_frac;
  logic              r_g, r_st;
  logic [31:0]       r_result;
  logic              r_dz, r_invalid;

  // Operand classification, valid while in UNPACK.
  logic w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
  logic signed [9:0] w_exp_diff;

  assign w_sign     = r_a[31] ^ r_b[31];
  assign w_a_zero   = (r_a[30:23] == 8'h00);
  assign w_b_zero   = (r_b[30:23] == 8'h00);
  assign w_a_inf    = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'h0);
  assign w_b_inf    = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'h0);
  assign w_a_nan    = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'h0);
  assign w_b_nan    = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'h0);
  assign w_special  = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;
  assign w_exp_diff = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;

  logic [31:0] w_spec_res;
  logic        w_spec_dz, w_spec_inv;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_spec_res = {w_sign, 31'h0};
    w_spec_dz  = 1'b0;
    w_spec_inv = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = 32'h7FC00000;
      w_spec_inv = 1'b1;
    end else if (w_a_inf || w_b_zero) begin
      w_spec_res = {w_sign, 8'hFF, 23'h0};
      w_spec_dz  = w_b_zero & ~w_a_inf;
    end
  end

  // One restoring step: the remainder never exceeds twice the divisor.
  logic        w_ge;
  logic [24:0] w_rem_sub;
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  logic              w_inc;
  logic [23:0]       w_frac_rnd;
  logic signed [9:0] w_e_fin;
  logic [22:0]       w_frac_fin;
  logic [31:0]       w_pack;

  assign w_inc      = r_g & (r_st | r_frac[0]);
  assign w_frac_rnd = {1'b0, r_frac} + {23'd0, w_inc};

  always_comb begin
    w_e_fin    = r_exp;
    w_frac_fin = w_frac_rnd[22:0];
    if (w_frac_rnd[23]) begin
      w_frac_fin = 23'h0;
      w_e_fin    = r_exp + 10'sd1;
    end
    if (w_e_fin >= 10'sd255)
      w_pack = {r_sign, 8'hFF, 23'h0};
    else if (w_e_fin <= 10'sd0)
      w_pack = {r_sign, 31'h0};
    else
      w_pack = {r_sign, w_e_fin[7:0], w_frac_fin};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_result  <= 32'h0;
      r_dz      <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.start) r_state <= S_UNPACK;
        S_UNPACK: begin
          if (w_special) begin
            r_state   <= S_DONE;
            r_result  <= w_spec_res;
            r_dz      <= w_spec_dz;
            r_invalid <= w_spec_inv;
          end else begin
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: if (r_cnt == 5'(QBITS - 1)) r_state <= S_NORM;
        S_NORM:   r_state <= S_ROUND;
        S_ROUND: begin
          r_state   <= S_DONE;
          r_result  <= w_pack;
          r_dz      <= 1'b0;
          r_invalid <= 1'b0;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are deliberately not reset; the FSM never consumes them before loading.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          r_a <= bus.a;
          r_b <= bus.b;
        end
      end
      S_UNPACK: begin
        r_sign <= w_sign;
        r_exp  <= w_exp_diff;
        r_rem  <= {2'b01, r_a[22:0]};
        r_mb   <= {1'b1, r_b[22:0]};
        r_q    <= '0;
        r_cnt  <= '0;
      end
      S_DIVIDE: begin
        r_q   <= {r_q[24:0], w_ge};
        r_rem <= {w_rem_sub[23:0], 1'b0};
        r_cnt <= r_cnt + 5'd1;
      end
      S_NORM: begin
        if (r_q[25]) begin
          r_frac <= r_q[24:2];
          r_g    <= r_q[1];
          r_st   <= r_q[0] | (r_rem != 25'd0);
        end else begin
          r_frac <= r_q[23:1];
          r_g    <= r_q[0];
          r_st   <= (r_rem != 25'd0);
          r_exp  <= r_exp - 10'sd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.result  = r_result;
  assign bus.dz      = r_dz;
  assign bus.invalid = r_invalid;
endmodule

// File: tb/tb_divf32_seq.sv
// Self-checking bench for divf32_seq: table of operand/expected records fed through a
// scoreboard queue, plus handshake and mid-divide reset sequences.
module tb_divf32_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divf32_if bus ();
  divf32_seq dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    logic        inv;
    bit          spec;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] last_res = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic dz, input logic inv, input bit sp);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.res = r; v.dz = dz; v.inv = inv; v.spec = sp;
    vecs.push_back(v);
  endtask

  // Latency counts the start-sampling edge as 1 and ends at the edge that raises done.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   lat;
    bit   seen;
    exp_q.push_back(v);
    @(negedge clk);
    bus.start = 1'b1; bus.a = v.a; bus.b = v.b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk); lat++; @(negedge clk);
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      n_checks++; n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", e.name, lat);
      return;
    end
    check({e.name, " result"}, bus.result, e.res);
    check({e.name, " dz"}, 32'(bus.dz), 32'(e.dz));
    check({e.name, " invalid"}, 32'(bus.invalid), 32'(e.inv));
    if (e.spec) begin
      n_checks++;
      if (lat > 3) begin
        n_err++;
        $display("FAIL %s latency: got %0d expected at most 3", e.name, lat);
      end
    end else begin
      check({e.name, " latency"}, 32'(lat), 32'd30);
    end
    last_res = e.res;
    @(negedge clk);
    check({e.name, " back to idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t e;
    int   n_done;
    bit   ignore_chk;

    add("25/5",        32'h41C80000, 32'h40A00000, 32'h40A00000, 0, 0, 0);
    add("-49.5/12",    32'hC2460000, 32'h41400000, 32'hC0840000, 0, 0, 0);
    add("1/3",         32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 0);
    add("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 0, 0, 0);
    add("2/1",         32'h40000000, 32'h3F800000, 32'h40000000, 0, 0, 0);
    add("1/2",         32'h3F800000, 32'h40000000, 32'h3F000000, 0, 0, 0);
    add("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 0, 0, 0);
    add("1/0",         32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 1);
    add("0/0",         32'h00000000, 32'h00000000, 32'h7FC00000, 0, 1, 1);
    add("0/-2",        32'h00000000, 32'hC0000000, 32'h80000000, 0, 0, 1);
    add("nan/1",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 0, 1, 1);
    add("inf/-inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 1, 1);
    add("-inf/2",      32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 1);
    add("3/inf",       32'h40400000, 32'h7F800000, 32'h00000000, 0, 0, 1);
    add("-2/0",        32'hC0000000, 32'h00000000, 32'hFF800000, 1, 0, 1);
    add("subn/1",      32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 1);
    add("1/subn",      32'h3F800000, 32'h00000001, 32'h7F800000, 1, 0, 1);

    bus.start = 1'b0; bus.a = 32'h0; bus.b = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'h0);
    check("reset dz", 32'(bus.dz), 32'd0);
    check("reset invalid", 32'(bus.invalid), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Second start while busy and a start during DONE are both ignored.
    exp_q.push_back(vecs[0]);
    @(negedge clk);
    bus.start = 1'b1; bus.a = vecs[0].a; bus.b = vecs[0].b;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40400000;
    n_done = 0;
    ignore_chk = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (ignore_chk) begin
        check("start in done ignored", 32'(bus.busy), 32'd0);
        ignore_chk = 1'b0;
      end
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          e = exp_q.pop_front();
          check("handshake result", bus.result, e.res);
          last_res = e.res;
          bus.start = 1'b1; bus.a = 32'h40000000; bus.b = 32'h3F800000;
          ignore_chk = 1'b1;
        end
      end
    end
    check("handshake done count", 32'(n_done), 32'd1);
    exp_q.delete();

    // Reset at cycle 10 of a divide discards it.
    @(negedge clk);
    bus.start = 1'b1; bus.a = vecs[1].a; bus.b = vecs[1].b;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy mid divide", 32'(bus.busy), 32'd1);
    check("result held while busy", bus.result, last_res);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset done", 32'(bus.done), 32'd0);
    check("mid reset result", bus.result, 32'h0);
    n_done = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("no done after reset", 32'(n_done), 32'd0);
    run_vec(vecs[2]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
